router_pkt_tx: RTL
==================

Name: router_pkt_tx

Overview:
- Packet source for the router input port; it is the transmit end of the byte-serial packet protocol that the router's input register stage receives.
- Each packet is a header byte, then 1..63 payload bytes, then one parity byte.
- The block takes a send request plus a payload stream from upstream and buffers the whole payload locally. It then drives header, payload and parity with no gaps, honours router back-pressure (busy), and records the router's parity-error verdict per packet.

Parameters:
- MAX_LEN, 63, largest legal payload length; also the depth of the internal payload buffer.
- GAP_CYCLES, 2, idle cycles inserted after each parity byte, minimum 2; the router's err is sampled on the last of them.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous and active-low
- start  input  1  send request; accepted only when tx_ready=1
- dest_addr  input  2  destination port; 2'b11 is illegal
- payload_len  input  6  payload byte count, 1..MAX_LEN
- tx_ready  output  1  high in IDLE only
- in_valid  input  1  upstream payload byte valid
- in_data  input  8  upstream payload byte
- in_ready  output  1  high in LOAD while byte count < captured length
- busy  input  1  router back-pressure
- pkt_valid  output  1  packet_valid to router
- data_out  output  8  data to router
- router_err  input  1  router parity-error flag
- pkt_done  output  1  one-cycle pulse when a packet completes
- pkt_err  output  1  one-cycle pulse, coincident with pkt_done, when router_err=1
- bad_req  output  1  one-cycle pulse when a request is rejected
- err_cnt  output  8  count of errored packets, saturates at 255

Behaviour:
- Reset (async assert, sync release): state IDLE; pkt_valid=0; data_out=0; all pulses 0; err_cnt=0; buffer pointers and count 0; parity 0. Reset mid-packet abandons the packet with no pulses.
- Header format: {payload_len[5:0], dest_addr[1:0]}.
- Parity: XOR of the header and every payload byte, computed during LOAD.
- A beat is consumed on any rising edge where state is HEADER, PAYLOAD or PARITY and busy=0. When busy=1, state, data_out and pkt_valid hold unchanged for any number of cycles.
- IDLE:
  - start=1 with len=0, len>MAX_LEN or dest_addr=3: pulse bad_req, stay in IDLE.
  - Legal start: capture the header, set parity to the header value, go to LOAD.
- LOAD: each edge with in_valid & in_ready writes in_data to the buffer, XORs it into parity and increments the count. When count reaches len, go to HEADER on the next edge. Loading has no timeout.
- HEADER: pkt_valid=1, data_out=header. On consume, go to PAYLOAD.
- PAYLOAD: pkt_valid=1, data_out=buffer[rd_ptr]. On each consume, rd_ptr increments. After byte len-1 is consumed, go to PARITY. pkt_valid never drops inside a packet.
- PARITY: pkt_valid=0, data_out=parity. On consume, go to GAP.
- GAP: pkt_valid=0, data_out=0 for GAP_CYCLES cycles. On the last cycle, sample router_err; on the exit edge, pulse pkt_done and, if router_err=1, pulse pkt_err and increment err_cnt (saturating). Then return to IDLE and reset the pointers.
- data_out and pkt_valid are registered outputs: the edge that consumes a beat loads the next beat.
- Back-to-back packets: the minimum spacing from parity to the next header is GAP_CYCLES + 1 + LOAD time.

Decomposition:
- Shared package router_pkg:
  - state enum: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP
  - header field positions
  - ADDR_ILLEGAL = 2'b11
  - MAX_LEN
- One natural sub-module: router_tx_buf, a simple dual-pointer byte RAM of depth MAX_LEN with write/read pointers and reset.

Test Plan:
- addr=1, len=3, payload 8'hA5, 8'h3C, 8'hFF, busy=0 -> data_out sequence 8'h0D, A5, 3C, FF with pkt_valid=1, then 8'h6B with pkt_valid=0; pkt_done 3 cycles after the parity beat.
- Same packet with busy=1 for 4 cycles during the 2nd payload byte -> data_out stays 8'h3C with pkt_valid=1 for 5 cycles; total packet is 4 cycles longer; parity still 8'h6B.
- len=0, or dest_addr=3 -> bad_req pulse, tx_ready stays 1, pkt_valid never rises.
- len=63 with payload 0..62 -> 65 beats driven, parity = XOR of header 8'hFC and 0..62; no gap in pkt_valid.
- router_err=1 during GAP on 3 packets -> pkt_err pulses with pkt_done each time, err_cnt=3. Force 256 errored packets -> err_cnt holds at 255.
- Reset asserted mid-PAYLOAD -> pkt_valid=0 and state IDLE immediately. The next legal packet is transmitted correctly with fresh parity.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router packet transmitter
package router_pkg;

    localparam int MAX_LEN    = 63;
    localparam int GAP_CYCLES = 2;

    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } tx_state_t;

    function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] h;
        h = '0;
        h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return h;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// rtl/router_pkt_tx_if.sv - byte-serial link between the packet transmitter and the router
interface router_pkt_tx_if;

    logic       busy;
    logic       router_err;
    logic       pkt_valid;
    logic [7:0] data_out;

    modport master (
        input  busy,
        input  router_err,
        output pkt_valid,
        output data_out
    );

    modport slave (
        output busy,
        output router_err,
        input  pkt_valid,
        input  data_out
    );

endinterface

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - payload byte RAM with independent write and read pointers
module router_tx_buf
    import router_pkg::*;
#(
    parameter int DEPTH = MAX_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic [5:0] wr_ptr,
    output logic [5:0] rd_ptr
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr < 6'(DEPTH))) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 6'd1;
            if (rd_en) rd_ptr <= rd_ptr + 6'd1;
        end
    end

    // rd_ptr parks one past the last byte after the final payload beat
    assign rd_data = (rd_ptr < 6'(DEPTH)) ? mem[rd_ptr] : 8'h00;

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffered packet source driving header, payload and parity into the router
module router_pkt_tx #(
    parameter int MAX_LEN    = router_pkg::MAX_LEN,
    parameter int GAP_CYCLES = router_pkg::GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            dest_addr,
    input  logic [5:0]            payload_len,
    output logic                  tx_ready,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    router_pkt_tx_if.master       lnk,
    output logic                  pkt_done,
    output logic                  pkt_err,
    output logic                  bad_req,
    output logic [7:0]            err_cnt
);
    import router_pkg::*;

    tx_state_t  state_q, state_d;
    logic [7:0] hdr_q, hdr_d;
    logic [5:0] len_q, len_d;
    logic [7:0] parity_q, parity_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       done_d, perr_d, bad_d;
    logic       wr_en, rd_en, buf_clr;
    logic [5:0] wr_cnt, rd_ptr;
    logic [7:0] rd_data;
    logic       consume;

    router_tx_buf #(.DEPTH(MAX_LEN)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (buf_clr),
        .wr_en   (wr_en),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .wr_ptr  (wr_cnt),
        .rd_ptr  (rd_ptr)
    );

    assign consume  = !lnk.busy;
    assign tx_ready = (state_q == IDLE);
    assign in_ready = (state_q == LOAD) && (wr_cnt < len_q);

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        len_d     = len_q;
        parity_d  = parity_q;
        data_d    = data_q;
        valid_d   = valid_q;
        gap_d     = gap_q;
        err_cnt_d = err_cnt_q;
        done_d    = 1'b0;
        perr_d    = 1'b0;
        bad_d     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        buf_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((payload_len == 6'd0) || ({1'b0, payload_len} > 7'(MAX_LEN)) ||
                        (dest_addr == ADDR_ILLEGAL)) begin
                        bad_d = 1'b1;
                    end else begin
                        hdr_d    = make_header(payload_len, dest_addr);
                        len_d    = payload_len;
                        parity_d = make_header(payload_len, dest_addr);
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                if (wr_cnt == len_q) begin
                    state_d = HEADER;
                    data_d  = hdr_q;
                    valid_d = 1'b1;
                end else if (in_valid) begin
                    wr_en    = 1'b1;
                    parity_d = parity_q ^ in_data;
                end
            end
            HEADER: begin
                if (consume) begin
                    state_d = PAYLOAD;
                    data_d  = rd_data;
                    rd_en   = 1'b1;
                end
            end
            PAYLOAD: begin
                // rd_ptr already points past the byte on data_out
                if (consume) begin
                    if (rd_ptr == len_q) begin
                        state_d = PARITY;
                        data_d  = parity_q;
                        valid_d = 1'b0;
                    end else begin
                        data_d = rd_data;
                        rd_en  = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (consume) begin
                    state_d = GAP;
                    data_d  = 8'h00;
                    gap_d   = 8'd0;
                end
            end
            GAP: begin
                if (gap_q == 8'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    perr_d  = lnk.router_err;
                    buf_clr = 1'b1;
                    if (lnk.router_err && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            len_q     <= '0;
            parity_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            gap_q     <= '0;
            err_cnt_q <= '0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            bad_req   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            len_q     <= len_d;
            parity_q  <= parity_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            gap_q     <= gap_d;
            err_cnt_q <= err_cnt_d;
            pkt_done  <= done_d;
            pkt_err   <= perr_d;
            bad_req   <= bad_d;
        end
    end

    assign lnk.pkt_valid = valid_q;
    assign lnk.data_out  = data_q;
    assign err_cnt       = err_cnt_q;

endmodule
